dac_spi_serializer: RTL and testbench

- Downstream stage of the tone generator. Accepts one 16-bit DAC sample per valid/ready handshake.
- Serializes each sample as a 24-bit SYNC-framed SPI write: 8-bit control word, then 16 data bits, MSB first.
- Drives the spi_data, spi_clk and spi_sync pins of an external 16-bit serial DAC (DAC8551-class; samples data on the SCLK falling edge).
- Mirrors the last accepted sample on a parallel 16-bit output for debug and LED use.

---
 rtl/tones_dac_pkg.sv | 12 +
 rtl/dac_spi_clk_gen.sv | 35 +++
 rtl/dac_spi_serializer.sv | 95 +++++++++
 tb/tb_dac_spi_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tones_dac_pkg.sv
// Shared types and frame geometry for the DAC SPI serializer.
package tones_dac_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned CTRL_W     = 8;

    localparam logic [CTRL_W-1:0] DEFAULT_CTRL_WORD = 8'h00;

endpackage

// File: rtl/dac_spi_clk_gen.sv
// SPI clock divider: idles high, toggles every CLK_DIV system clocks while enabled.
module dac_spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic spi_clk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          tick;

    assign tick      = en && (div_cnt == TERM);
    assign rise_tick = tick && !spi_clk;
    assign fall_tick = tick && spi_clk;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div_cnt <= '0;
            spi_clk <= 1'b1;
        end else if (tick) begin
            div_cnt <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes 16-bit samples into 24-bit SYNC-framed SPI writes for a DAC8551-class DAC.
module dac_spi_serializer
    import tones_dac_pkg::*;
#(
    parameter int unsigned       CLK_DIV   = 4,
    parameter int unsigned       SYNC_IDLE = 4,
    parameter logic [CTRL_W-1:0] CTRL_WORD = DEFAULT_CTRL_WORD
) (
    input  logic                clock_clk,
    input  logic                reset_reset_n,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                spi_data,
    output logic                spi_clk,
    output logic                spi_sync,
    output logic                frame_done,
    output logic [SAMPLE_W-1:0] dac_out_data
);

    localparam int unsigned GW = (SYNC_IDLE > 1) ? $clog2(SYNC_IDLE) : 1;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [4:0]              bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic                    rise_tick;
    logic                    fall_tick;

    assign sample_ready = (state == IDLE);

    dac_spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clock_clk),
        .rst_n    (reset_reset_n),
        .en       (state == SHIFT),
        .spi_clk  (spi_clk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            spi_data     <= 1'b0;
            spi_sync     <= 1'b1;
            frame_done   <= 1'b0;
            dac_out_data <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        shift_reg    <= {CTRL_WORD, sample_data};
                        dac_out_data <= sample_data;
                        bit_cnt      <= 5'(FRAME_BITS - 1);
                        spi_sync     <= 1'b0;
                        spi_data     <= CTRL_WORD[CTRL_W-1];
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Data only moves on the rising SCLK edge, keeping it stable around each fall.
                    if (rise_tick) begin
                        if (bit_cnt != '0) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            spi_data  <= shift_reg[FRAME_BITS-2];
                            bit_cnt   <= bit_cnt - 1'b1;
                        end else begin
                            spi_sync   <= 1'b1;
                            spi_data   <= 1'b0;
                            frame_done <= 1'b1;
                            gap_cnt    <= GW'(SYNC_IDLE - 1);
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The DAC samples on SCLK falls, which must only happen inside an active frame.
    a_fall_in_frame: assert property (@(posedge clock_clk) disable iff (!reset_reset_n)
        fall_tick |-> !spi_sync);

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed self-checking bench for dac_spi_serializer across three parameter sets.
module tb_dac_spi_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    int          sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        valid_i [3];
    logic        ready_o [3];
    logic        sdata_o [3];
    logic        sclk_o  [3];
    logic        sync_o  [3];
    logic        done_o  [3];
    logic [15:0] dac_o   [3];

    logic        m_ready, m_data, m_clk, m_sync, m_done;
    logic [15:0] m_dac;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_i[0] = valid && (sel == 0);
    assign valid_i[1] = valid && (sel == 1);
    assign valid_i[2] = valid && (sel == 2);

    always_comb begin
        m_ready = ready_o[sel];
        m_data  = sdata_o[sel];
        m_clk   = sclk_o[sel];
        m_sync  = sync_o[sel];
        m_done  = done_o[sel];
        m_dac   = dac_o[sel];
    end

    dac_spi_serializer #(.CLK_DIV(4), .SYNC_IDLE(4), .CTRL_WORD(8'h00)) u_dut_a (
        .clock_clk(clk), .reset_reset_n(rst_n), .sample_data(data), .sample_valid(valid_i[0]),
        .sample_ready(ready_o[0]), .spi_data(sdata_o[0]), .spi_clk(sclk_o[0]),
        .spi_sync(sync_o[0]), .frame_done(done_o[0]), .dac_out_data(dac_o[0]));

    dac_spi_serializer #(.CLK_DIV(2), .SYNC_IDLE(4), .CTRL_WORD(8'h00)) u_dut_b (
        .clock_clk(clk), .reset_reset_n(rst_n), .sample_data(data), .sample_valid(valid_i[1]),
        .sample_ready(ready_o[1]), .spi_data(sdata_o[1]), .spi_clk(sclk_o[1]),
        .spi_sync(sync_o[1]), .frame_done(done_o[1]), .dac_out_data(dac_o[1]));

    dac_spi_serializer #(.CLK_DIV(1), .SYNC_IDLE(4), .CTRL_WORD(8'h03)) u_dut_c (
        .clock_clk(clk), .reset_reset_n(rst_n), .sample_data(data), .sample_valid(valid_i[2]),
        .sample_ready(ready_o[2]), .spi_data(sdata_o[2]), .spi_clk(sclk_o[2]),
        .spi_sync(sync_o[2]), .frame_done(done_o[2]), .dac_out_data(dac_o[2]));

    // Raise valid, wait for ready, complete the handshake; returns just after edge T.
    task automatic send(input logic [15:0] d, input bit keep_valid, output int t_cyc);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        for (int n = 0; n < 500; n++) begin
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: ready=%b required 1 within 500 cycles", m_ready);
        end
        @(posedge clk);
        #1;
        t_cyc = cyc;
        if (!keep_valid) valid = 1'b0;
    endtask

    // Follows one frame from the cycle after the handshake until spi_sync returns high.
    task automatic capture(output logic [23:0] w, output int falls, output int low,
                           output int done, output int period);
        logic prev_clk;
        int   last_fall;
        bit   ended;
        w = '0; falls = 0; low = 0; done = 0; period = 0;
        prev_clk = 1'b1; last_fall = -1; ended = 1'b0;
        for (int n = 0; n < 3000 && !ended; n++) begin
            @(negedge clk);
            if (m_done) done++;
            if (!m_sync) begin
                low++;
                if (prev_clk && !m_clk) begin
                    falls++;
                    w = {w[22:0], m_data};
                    if (last_fall >= 0 && period == 0) period = n - last_fall;
                    last_fall = n;
                end
            end else if (low > 0) begin
                ended = 1'b1;
            end
            prev_clk = m_clk;
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: spi_sync=%b never returned high", m_sync);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_sync !== 1'b1) begin errors++; $display("FAIL reset_sync: got %b required 1", m_sync); end
        checks++; if (m_clk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b required 1", m_clk); end
        checks++; if (m_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b required 0", m_data); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", m_done); end
        checks++; if (m_dac !== 16'h0000) begin errors++; $display("FAIL reset_dac: got %h required 0000", m_dac); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", m_ready); end
    endtask

    task automatic test_single_frame();
        logic [23:0] w;
        int falls, low, done, period, t;
        sel = 0;
        send(16'hA5C3, 1'b0, t);
        capture(w, falls, low, done, period);
        checks++; if (w !== 24'h00A5C3) begin errors++; $display("FAIL single_word: got %h required 00a5c3", w); end
        checks++; if (falls != 24) begin errors++; $display("FAIL single_falls: got %0d required 24", falls); end
        checks++; if (low != 192) begin errors++; $display("FAIL single_sync_low: got %0d required 192", low); end
        checks++; if (done != 1) begin errors++; $display("FAIL single_done: got %0d required 1", done); end
        checks++; if (period != 8) begin errors++; $display("FAIL single_period: got %0d required 8", period); end
        checks++; if (m_dac !== 16'hA5C3) begin errors++; $display("FAIL single_dac: got %h required a5c3", m_dac); end
    endtask

    task automatic test_valid_ignored();
        logic [23:0] w;
        int falls, low, done, period, t;
        logic ready_at_pulse;
        sel = 0;
        repeat (10) @(negedge clk);
        send(16'h5A5A, 1'b0, t);
        fork
            capture(w, falls, low, done, period);
            begin
                repeat (20) @(negedge clk);
                valid = 1'b1;
                data  = 16'h1234;
                ready_at_pulse = m_ready;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        checks++; if (ready_at_pulse !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b required 0", ready_at_pulse); end
        checks++; if (w !== 24'h005A5A) begin errors++; $display("FAIL ignore_word: got %h required 005a5a", w); end
        checks++; if (m_dac !== 16'h5A5A) begin errors++; $display("FAIL ignore_dac: got %h required 5a5a", m_dac); end
        repeat (12) @(negedge clk);
        checks++; if (m_sync !== 1'b1 || m_ready !== 1'b1) begin
            errors++; $display("FAIL ignore_no_frame: sync=%b ready=%b required 1 1", m_sync, m_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] w1, w2;
        int falls, low, done, period, t1, t2, hi, gap_hi;
        bit ok;
        sel = 1;
        send(16'h0001, 1'b1, t1);
        data = 16'hFFFF;
        capture(w1, falls, low, done, period);
        hi = 1; gap_hi = 1; ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_ready) begin
                if (m_sync) hi++;
                ok = 1'b1;
                break;
            end
            if (m_sync) begin hi++; gap_hi++; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_gap_timeout: ready=%b required 1", m_ready); end
        @(posedge clk);
        #1;
        t2 = cyc;
        valid = 1'b0;
        checks++; if (w1 !== 24'h000001) begin errors++; $display("FAIL b2b_word1: got %h required 000001", w1); end
        checks++; if (t2 - t1 != 101) begin errors++; $display("FAIL b2b_spacing: got %0d required 101", t2 - t1); end
        checks++; if (gap_hi != 4) begin errors++; $display("FAIL b2b_gap_high: got %0d required 4", gap_hi); end
        checks++; if (hi != 5) begin errors++; $display("FAIL b2b_sync_high_total: got %0d required 5", hi); end
        capture(w2, falls, low, done, period);
        checks++; if (w2 !== 24'h00FFFF) begin errors++; $display("FAIL b2b_word2: got %h required 00ffff", w2); end
        checks++; if (low != 96) begin errors++; $display("FAIL b2b_sync_low: got %0d required 96", low); end
        checks++; if (m_dac !== 16'hFFFF) begin errors++; $display("FAIL b2b_dac: got %h required ffff", m_dac); end
    endtask

    task automatic test_mid_reset();
        logic prev_clk;
        int   falls, done, t;
        bit   ok;
        sel = 0;
        repeat (10) @(negedge clk);
        send(16'hFFFF, 1'b0, t);
        prev_clk = 1'b1; falls = 0; done = 0; ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (m_done) done++;
            if (prev_clk && !m_clk) falls++;
            prev_clk = m_clk;
            if (falls == 10) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || m_data !== 1'b1) begin
            errors++; $display("FAIL mrst_pre: falls=%0d data=%b required 10 1", falls, m_data);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (m_sync !== 1'b1 || m_clk !== 1'b1 || m_data !== 1'b0) begin
            errors++; $display("FAIL mrst_pins: sync=%b sclk=%b data=%b required 1 1 0", m_sync, m_clk, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (m_done) done++;
        end
        checks++; if (done != 0) begin errors++; $display("FAIL mrst_done: got %0d required 0", done); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b required 1", m_ready); end
    endtask

    task automatic test_clk_div1();
        logic [23:0] w;
        int falls, low, done, period, t;
        sel = 2;
        send(16'h8000, 1'b0, t);
        capture(w, falls, low, done, period);
        checks++; if (w !== 24'h038000) begin errors++; $display("FAIL div1_word: got %h required 038000", w); end
        checks++; if (falls != 24) begin errors++; $display("FAIL div1_falls: got %0d required 24", falls); end
        checks++; if (period != 2) begin errors++; $display("FAIL div1_period: got %0d required 2", period); end
        checks++; if (low != 48) begin errors++; $display("FAIL div1_sync_low: got %0d required 48", low); end
        checks++; if (done != 1) begin errors++; $display("FAIL div1_done: got %0d required 1", done); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_valid_ignored();
        test_back_to_back();
        test_mid_reset();
        test_clk_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
